// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit (muldiv_seq).
//   state_e    : sequencer states IDLE/RUN/FIX/DONE with fixed 2-bit encodings
//   OpMul/OpDiv: operation select codes carried on port op
//   LastIter   : counter value of the final RUN iteration (8 iterations, 0..7)
//   neg8       : two's-complement negation of a byte
package muldiv_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic       OpMul    = 1'b0;
  localparam logic       OpDiv    = 1'b1;
  localparam logic [2:0] LastIter = 3'd7;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

endpackage

// File: rtl/addsub8.sv
// 8-bit adder/subtractor shared by the multiply and divide sequences.
//   a, b  : operands
//   sub   : 1 = a + ~b + cin (subtract when cin=1), 0 = a + b + cin
//   cin   : carry in
//   sum   : 8-bit result
//   cout8 : carry out of bit 7 (for subtract: 1 = no borrow)
//   cout4 : carry out of bit 3 (half carry)
module addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout8,
  output logic       cout4
);

  logic [7:0] b_eff;
  logic [4:0] lo_nib;
  logic [4:0] hi_nib;

  always_comb begin
    b_eff  = sub ? ~b : b;
    lo_nib = {1'b0, a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, cin};
    hi_nib = {1'b0, a[7:4]} + {1'b0, b_eff[7:4]} + {4'b0000, lo_nib[4]};
    sum    = {hi_nib[3:0], lo_nib[3:0]};
    cout4  = lo_nib[4];
    cout8  = hi_nib[4];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 8x8 unsigned multiplier and 8/8 restoring divider for the extended ALU.
// One shared addsub8 performs one add or subtract per clock over 8 RUN iterations.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : request, sampled only in IDLE
//   op         : 0 = multiply, 1 = divide
//   op_signed  : two's-complement operands (only with MULDIV_SIGNED_EN)
//   opa, opb   : multiplicand/dividend, multiplier/divisor
//   busy       : operation in progress
//   done       : one-cycle pulse, results valid
//   res_hi     : product[15:8] / remainder
//   res_lo     : product[7:0]  / quotient
//   dbz        : divide-by-zero flag for the current result
//
// Configuration macro MULDIV_SIGNED_EN: when defined, op_signed=1 selects signed
// operation (magnitudes computed at start, one FIX cycle restores result signs).
// Undefined: op_signed is ignored and all operations are unsigned.
import muldiv_seq_pkg::*;

module muldiv_seq #(
  parameter logic [7:0] DBZ_QUOT = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       op,
  input  logic       op_signed,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo,
  output logic       dbz
);

  state_e     state_q, state_d;
  logic       op_q, op_d;
  logic [7:0] acc_hi_q, acc_hi_d;  // partial product high / remainder
  logic [7:0] acc_lo_q, acc_lo_d;  // multiplier shifting out / quotient shifting in
  logic [7:0] opnd_q, opnd_d;      // multiplicand or divisor
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] res_hi_q, res_hi_d;
  logic [7:0] res_lo_q, res_lo_d;
  logic       dbz_q, dbz_d;

  // Operand magnitudes, sign-fix results and FIX routing (differ per build)
  logic [7:0] mag_a, mag_b;
  logic [7:0] fix_hi, fix_lo;
  logic       go_fix;

  // Shared adder
  logic [7:0] add_a, add_b, add_sum;
  logic       add_sub, add_cin, add_cout;
  logic       unused_cout4;

  // Per-iteration datapath results
  logic       div_msb;
  logic [7:0] div_shl;
  logic       div_take;
  logic [7:0] iter_hi, iter_lo;

  addsub8 u_addsub8 (
    .a     (add_a),
    .b     (add_b),
    .sub   (add_sub),
    .cin   (add_cin),
    .sum   (add_sum),
    .cout8 (add_cout),
    .cout4 (unused_cout4)
  );

  always_comb begin
    div_msb  = acc_hi_q[7];
    div_shl  = {acc_hi_q[6:0], acc_lo_q[7]};
    div_take = 1'b0;
    if (op_q == OpDiv) begin
      add_a    = div_shl;
      add_b    = opnd_q;
      add_sub  = 1'b1;
      add_cin  = 1'b1;
      // A set msb means the 9-bit shifted remainder already exceeds any divisor
      div_take = div_msb | add_cout;
      iter_hi  = div_take ? add_sum : div_shl;
      iter_lo  = {acc_lo_q[6:0], div_take};
    end else begin
      add_a    = acc_hi_q;
      add_b    = acc_lo_q[0] ? opnd_q : 8'h00;
      add_sub  = 1'b0;
      add_cin  = 1'b0;
      iter_hi  = {add_cout, add_sum[7:1]};
      iter_lo  = {add_sum[0], acc_lo_q[7:1]};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic sgn_q, sgn_d;
  logic neg_lo_q, neg_lo_d;  // negate product / quotient
  logic neg_hi_q, neg_hi_d;  // negate remainder (follows dividend sign)
  logic a_neg, b_neg;

  always_comb begin
    a_neg = op_signed & opa[7];
    b_neg = op_signed & opb[7];
    mag_a = a_neg ? neg8(opa) : opa;
    mag_b = b_neg ? neg8(opb) : opb;
  end

  always_comb begin
    sgn_d    = sgn_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (state_q == StIdle && start) begin
      sgn_d    = op_signed;
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = a_neg;
    end
  end

  always_comb begin
    if (op_q == OpMul) begin
      {fix_hi, fix_lo} = neg_lo_q ? (~{acc_hi_q, acc_lo_q} + 16'd1) : {acc_hi_q, acc_lo_q};
    end else begin
      fix_lo = neg_lo_q ? neg8(acc_lo_q) : acc_lo_q;
      fix_hi = neg_hi_q ? neg8(acc_hi_q) : acc_hi_q;
    end
  end

  assign go_fix = sgn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      sgn_q    <= sgn_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign mag_a            = opa;
  assign mag_b            = opb;
  assign fix_hi           = acc_hi_q;
  assign fix_lo           = acc_lo_q;
  assign go_fix           = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d  = op;
          cnt_d = 3'd0;
          dbz_d = 1'b0;
          if (op == OpDiv && opb == 8'h00) begin
            res_lo_d = DBZ_QUOT;
            res_hi_d = opa;
            dbz_d    = 1'b1;
            state_d  = StDone;
          end else begin
            acc_hi_d = 8'h00;
            acc_lo_d = (op == OpDiv) ? mag_a : mag_b;
            opnd_d   = (op == OpDiv) ? mag_b : mag_a;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        acc_hi_d = iter_hi;
        acc_lo_d = iter_lo;
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == LastIter) begin
          if (go_fix) begin
            state_d = StFix;
          end else begin
            res_hi_d = iter_hi;
            res_lo_d = iter_lo;
            state_d  = StDone;
          end
        end
      end
      StFix: begin
        res_hi_d = fix_hi;
        res_lo_d = fix_lo;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      acc_hi_q <= 8'h00;
      acc_lo_q <= 8'h00;
      opnd_q   <= 8'h00;
      cnt_q    <= 3'd0;
      res_hi_q <= 8'h00;
      res_lo_q <= 8'h00;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy   = (state_q == StRun) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_muldiv_seq;

  localparam logic [7:0] DbzQuot = 8'hFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic       op_signed = 1'b0;
  logic [7:0] opa = 8'h00;
  logic [7:0] opb = 8'h00;
  logic       busy, done, dbz;
  logic [7:0] res_hi, res_lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(.DBZ_QUOT(DbzQuot)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .op_signed (op_signed),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {dbz, hi, lo, latency[7:0]} from plain integer arithmetic.
  function automatic logic [24:0] model(input logic o, input logic s,
                                        input logic [7:0] a, input logic [7:0] b);
    logic sg;
    int   ia, ib, p, q, r;
    logic [7:0] hi, lo, lat;
`ifdef MULDIV_SIGNED_EN
    sg = s;
`else
    sg = 1'b0;
    if (s) sg = 1'b0;
`endif
    ia  = sg ? int'($signed(a)) : int'(a);
    ib  = sg ? int'($signed(b)) : int'(b);
    lat = sg ? 8'd10 : 8'd9;
    if (!o) begin
      p  = ia * ib;
      hi = p[15:8];
      lo = p[7:0];
      return {1'b0, hi, lo, lat};
    end
    if (b == 8'h00) return {1'b1, a, DbzQuot, 8'd1};
    q  = ia / ib;
    r  = ia % ib;
    hi = r[7:0];
    lo = q[7:0];
    return {1'b0, hi, lo, lat};
  endfunction

  task automatic run_op(input logic o, input logic s, input logic [7:0] a, input logic [7:0] b);
    logic [24:0] exp;
    int edges;
    exp = model(o, s, a, b);
    @(negedge clk);
    start = 1'b1; op = o; op_signed = s; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    if (!(o && b == 8'h00)) check_eq("dbz_clr", {31'd0, dbz}, 32'd0);
    while (!done && edges < 20) begin
      check_eq("busy_run", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      edges++;
    end
    check_eq("latency", edges, {24'd0, exp[7:0]});
    check_eq("busy_done", {31'd0, busy}, 32'd0);
    check_eq("res", {16'd0, res_hi, res_lo}, {16'd0, exp[23:8]});
    check_eq("dbz", {31'd0, dbz}, {31'd0, exp[24]});
    @(posedge clk); #1;
    check_eq("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ndone, done_edge;
    logic o, s;
    logic [7:0] a, b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_res", {16'd0, res_hi, res_lo}, 32'd0);
    check_eq("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(1'b0, 1'b0, 8'hFF, 8'hFF);
    check_eq("max_mul", {16'd0, res_hi, res_lo}, 32'h0000FE01);
    run_op(1'b1, 1'b0, 8'd200, 8'd7);
    check_eq("div200_7", {16'd0, res_hi, res_lo}, 32'h0000041C);
    run_op(1'b1, 1'b0, 8'h55, 8'h00);
    check_eq("dbz_res", {15'd0, dbz, res_hi, res_lo}, 32'h000155FF);
    run_op(1'b0, 1'b0, 8'd3, 8'd4);
    run_op(1'b0, 1'b1, 8'hFA, 8'h07);
`ifdef MULDIV_SIGNED_EN
    check_eq("smul", {16'd0, res_hi, res_lo}, 32'h0000FFD6);
    run_op(1'b1, 1'b1, 8'hF9, 8'h02);
    check_eq("sdiv", {16'd0, res_hi, res_lo}, 32'h0000FFFD);
    run_op(1'b1, 1'b1, 8'h80, 8'hFF);
    check_eq("sdiv_wrap", {24'd0, res_lo}, 32'h00000080);
`else
    check_eq("umul_sgn", {16'd0, res_hi, res_lo}, 32'h000006D6);
`endif
    run_op(1'b1, 1'b1, 8'h80, 8'h00);

    // Start while busy: pulses at edges 3 and 5 must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; op_signed = 1'b0; opa = 8'hFF; opb = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    done_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 5);
      op = 1'b1; opa = 8'h12; opb = 8'h00;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        done_edge = i;
        check_eq("busy_start_res", {16'd0, res_hi, res_lo}, 32'h0000FE01);
      end
    end
    start = 1'b0;
    check_eq("busy_start_ndone", ndone, 1);
    check_eq("busy_start_edge", done_edge, 8);
    check_eq("busy_start_dbz", {31'd0, dbz}, 32'd0);

    // Reset mid-operation at edge 4 of a divide
    @(negedge clk);
    start = 1'b1; op = 1'b1; opa = 8'd200; opb = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rst = (i == 4);
      @(posedge clk); #1;
    end
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_res", {16'd0, res_hi, res_lo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_eq("mid_rst_nodone", ndone, 0);
    run_op(1'b1, 1'b0, 8'd200, 8'd7);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if (n % 10 == 0) a = 8'h80;
      run_op(o, s, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
